encoder_top: RTL and testbench

//  Keccak-style "rotate" (rho) step for a 5x5x64 bit state matrix.
//  - State arrives as 64 slices of 25 bits; slice z is fetched from an external memory addressed by cnt_value.
//  - Each of the 25 lanes (x,y) is rotated along z by a fixed offset.
//  - The 64 result slices are streamed out through a write strobe, then completion is signalled on donee.

---
 rtl/encoder_top.sv | 136 +++++++++++++
 tb/tb_encoder_top.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/encoder_top.sv
// Keccak rho step: loads 64 slices of a 5x5x64 state, rotates each lane along z,
// and streams the rotated slices back out one strobe per slice.
module encoder_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        rotate_en,
    output logic        donee,
    output logic [5:0]  cnt_value,
    input  logic [24:0] line_in,
    output logic        write_enable,
    output logic [24:0] write_value
);

    localparam int unsigned LINE_W = 25;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned IDX_W  = 6;

    // Rotation offset per slice bit i = 5*y + x.
    localparam int unsigned ROT_OFF [LINE_W] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WR_A,
        S_WR_B,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                donee_q;
    logic                we_q;
    logic [IDX_W-1:0]    cnt_q;
    logic [LINE_W-1:0]   wv_q;
    logic [LINE_W-1:0]   mem_q [DEPTH];

    logic [IDX_W-1:0]    rot_z_d;
    logic [LINE_W-1:0]   slice_d;
    logic [IDX_W-1:0]    src_d;

    // Slice to emit next; on the final LOAD cycle slice 63 is still on line_in,
    // so it is bypassed straight into the rotation instead of read from mem_q.
    always_comb begin
        rot_z_d = (state_q == S_LOAD) ? '0 : cnt_q + 6'd1;
        slice_d = '0;
        src_d   = '0;
        for (int unsigned i = 0; i < LINE_W; i++) begin
            src_d = rot_z_d - IDX_W'(ROT_OFF[i]);
            if ((state_q == S_LOAD) && (src_d == '1)) begin
                slice_d[i] = line_in[i];
            end else begin
                slice_d[i] = mem_q[src_d][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && (state_q == S_LOAD)) begin
            mem_q[cnt_q] <= line_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            donee_q <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            wv_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    donee_q <= 1'b0;
                    we_q    <= 1'b0;
                    cnt_q   <= '0;
                    wv_q    <= '0;
                    if (rotate_en) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt_q == '1) begin
                        state_q <= S_WR_A;
                        we_q    <= 1'b1;
                        wv_q    <= slice_d;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 6'd1;
                    end
                end
                S_WR_A: begin
                    state_q <= S_WR_B;
                    we_q    <= 1'b0;
                end
                S_WR_B: begin
                    if (cnt_q == '1) begin
                        state_q <= S_DONE;
                        donee_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_WR_A;
                        we_q    <= 1'b1;
                        wv_q    <= slice_d;
                        cnt_q   <= cnt_q + 6'd1;
                    end
                end
                S_DONE: begin
                    we_q <= 1'b0;
                    if (!rotate_en) begin
                        state_q <= S_IDLE;
                        donee_q <= 1'b0;
                        wv_q    <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    donee_q <= 1'b0;
                    we_q    <= 1'b0;
                    cnt_q   <= '0;
                    wv_q    <= '0;
                end
            endcase
        end
    end

    assign donee        = donee_q;
    assign write_enable = we_q;
    assign cnt_value    = cnt_q;
    assign write_value  = wv_q;

endmodule

// File: tb/tb_encoder_top.sv
// Directed/randomised bench for encoder_top against a plain-arithmetic rho model.
module tb_encoder_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rotate_en = 1'b0;
    logic        donee;
    logic [5:0]  cnt_value;
    logic [24:0] line_in;
    logic        write_enable;
    logic [24:0] write_value;

    logic [24:0] mem [64];
    int errors = 0;
    int checks = 0;

    // Offsets indexed [x][y]
    int R [5][5] = '{
        '{ 0, 36,  3, 41, 18},
        '{ 1, 44, 10, 45,  2},
        '{62,  6, 43, 15, 61},
        '{28, 55, 25, 21, 56},
        '{27, 20, 39,  8, 14}
    };

    encoder_top dut (
        .clk          (clk),
        .rst          (rst),
        .rotate_en    (rotate_en),
        .donee        (donee),
        .cnt_value    (cnt_value),
        .line_in      (line_in),
        .write_enable (write_enable),
        .write_value  (write_value)
    );

    always #5 clk = ~clk;

    assign line_in = mem[cnt_value];

    function automatic logic [24:0] model(input int z);
        logic [24:0] res;
        int s;
        res = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                s = (((z - R[x][y]) % 64) + 64) % 64;
                res[5*y + x] = mem[s][5*y + x];
            end
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_and_check(input string tag, input int hold, input bit drop_mid);
        int strobes;
        int done_c;
        strobes = 0;
        done_c  = 0;
        @(negedge clk);
        rotate_en = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 400 && done_c == 0; c++) begin
            @(posedge clk);
            #1;
            if (c < 64) begin
                check({tag, "_load_cnt"}, 32'(cnt_value), 32'(c));
                check({tag, "_load_we"}, 32'(write_enable), 32'd0);
            end else if (c < 192) begin
                check({tag, "_we_pattern"}, 32'(write_enable), 32'(((c - 64) % 2) == 0));
                if (write_enable) begin
                    check({tag, "_value"}, 32'(write_value), 32'(model(strobes)));
                    check({tag, "_wr_cnt"}, 32'(cnt_value), 32'(strobes));
                    strobes++;
                end
            end
            if (drop_mid && c == 100) rotate_en = 1'b0;
            if (donee) done_c = c;
        end
        check({tag, "_done_cycle"}, 32'(done_c), 32'd192);
        check({tag, "_strobes"}, 32'(strobes), 32'd64);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_done"}, 32'(donee), 32'd1);
            check({tag, "_hold_we"}, 32'(write_enable), 32'd0);
        end
        rotate_en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_idle_done"}, 32'(donee), 32'd0);
        check({tag, "_idle_cnt"}, 32'(cnt_value), 32'd0);
        check({tag, "_idle_we"}, 32'(write_enable), 32'd0);
    endtask

    initial begin
        int stray;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // Reset held with rotate_en high
        rotate_en = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("rst_done", 32'(donee), 32'd0);
            check("rst_we", 32'(write_enable), 32'd0);
            check("rst_cnt", 32'(cnt_value), 32'd0);
            check("rst_wv", 32'(write_value), 32'd0);
        end
        @(negedge clk);
        rotate_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);

        run_and_check("zero", 3, 1'b0);

        for (int i = 0; i < 64; i++) mem[i] = 25'(i % 2);
        run_and_check("lane00", 3, 1'b0);

        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 25'd2;
        run_and_check("single", 3, 1'b0);
        check("single_exp_slice1", 32'(model(1)), 32'd2);

        mem[0] = '0;
        mem[63] = 25'(1 << 10);
        run_and_check("wrap", 3, 1'b0);
        check("wrap_exp_slice2", 32'(model(2)), 32'(1 << 10));

        for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
        run_and_check("random", 20, 1'b0);
        run_and_check("rerun", 2, 1'b0);
        run_and_check("dropmid", 0, 1'b1);

        // Abort in the middle of WRITE
        @(negedge clk);
        rotate_en = 1'b1;
        for (int k = 0; k < 120; k++) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("abort_we", 32'(write_enable), 32'd0);
            check("abort_done", 32'(donee), 32'd0);
            check("abort_cnt", 32'(cnt_value), 32'd0);
            check("abort_wv", 32'(write_value), 32'd0);
        end
        rotate_en = 1'b0;
        rst = 1'b1;
        stray = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (write_enable || donee) stray++;
        end
        check("abort_no_strobes", 32'(stray), 32'd0);

        for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
        run_and_check("post_abort", 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
